// File: rtl/phase_selector_track_if.sv
// phase_selector_track_if
//   Bundles the data and control signals of phase_selector_track.
//   mode     : 0 = manual phase select, 1 = automatic tracking
//   phsel    : manual phase select, 0..2*NPHASE-1
//   serin    : NPHASE oversampled bits per clock, bit 0 oldest
//   serout   : recovered bit stream
//   curphase : phase currently driving the mux tree
//   locked   : automatic mode has a valid, applied phase
//   master drives mode/phsel/serin; slave (the selector) drives the rest.
interface phase_selector_track_if #(
    parameter int unsigned NPHASE = 8
);
    localparam int unsigned S = $clog2(2 * NPHASE);

    logic           mode;
    logic [S-1:0]   phsel;
    logic [NPHASE-1:0] serin;
    logic           serout;
    logic [S-1:0]   curphase;
    logic           locked;

    modport master (
        output mode, phsel, serin,
        input  serout, curphase, locked
    );

    modport slave (
        input  mode, phsel, serin,
        output serout, curphase, locked
    );
endinterface

// File: rtl/phase_selector_track.sv
// phase_selector_track
//   Oversampling phase selector with automatic mid-eye tracking.
//   Each clock NPHASE samples arrive; together with the previous clock's
//   samples they form 2*NPHASE phases, reduced to one bit by an S-stage
//   registered binary mux tree steered by curphase.
//   In automatic mode an edge histogram is collected over WIN clocks,
//   the peak bin is found by a sequential scan, and the sampling phase
//   moves half a unit interval away from the peak, with one-window
//   hysteresis and a lock indicator.
// Ports:
//   CLK400 : sole clock
//   reset  : synchronous, active-high
//   bus    : slave side of phase_selector_track_if
//            (mode, phsel, serin in; serout, curphase, locked out)
module phase_selector_track #(
    parameter int unsigned NPHASE  = 8,
    parameter int unsigned WIN     = 256,
    parameter int unsigned MINEDGE = 16
) (
    input  logic                   CLK400,
    input  logic                   reset,
    phase_selector_track_if.slave  bus
);
    localparam int unsigned S  = $clog2(2 * NPHASE);
    localparam int unsigned PB = $clog2(NPHASE);
    localparam int unsigned WB = $clog2(WIN);
    localparam int unsigned CW = WB + 1;
    localparam int unsigned TW = 2 * NPHASE - 1;

    localparam logic [WB-1:0] WIN_LAST = WB'(WIN - 1);
    localparam logic [PB-1:0] IDX_LAST = PB'(NPHASE - 1);
    localparam logic [PB-1:0] HALF     = PB'(NPHASE / 2);
    localparam logic [CW-1:0] MIN_CNT  = CW'(MINEDGE);

    typedef enum logic [1:0] {
        MANUAL,
        ACQUIRE,
        LOCKED,
        PENDING
    } state_e;

    state_e               state_q, state_d;
    logic [NPHASE-1:0]    serdel_q, serdel_d;
    logic [TW-1:0]        tree_q, tree_d;
    logic [S-1:0]         curphase_q, curphase_d;
    logic                 locked_q, locked_d;
    logic [S-1:0]         cand_q, cand_d;
    logic [WB-1:0]        wincnt_q, wincnt_d;
    logic [CW-1:0]        cnt_q  [NPHASE];
    logic [CW-1:0]        cnt_d  [NPHASE];
    logic [CW-1:0]        snap_q [NPHASE];
    logic [CW-1:0]        snap_d [NPHASE];
    logic                 scan_act_q, scan_act_d;
    logic [PB-1:0]        scan_idx_q, scan_idx_d;
    logic [PB-1:0]        best_p_q, best_p_d;
    logic [CW-1:0]        best_cnt_q, best_cnt_d;
    logic                 res_q, res_d;

    logic [2*NPHASE-1:0]  ser;
    logic [NPHASE-1:0]    edge_v;
    logic [4*NPHASE-3:0]  tree_in;
    logic [S-1:0]         tgt;
    logic                 win_valid;

    assign ser    = {bus.serin, serdel_q};
    // e[p] compares phase NPHASE+p with the one just before it, so e[0]
    // spans the boundary between the previous and current clock's samples.
    assign edge_v = ser[2*NPHASE-1:NPHASE] ^ ser[2*NPHASE-2:NPHASE-1];

    // All mux-tree stages live in one flat vector: stage j (width
    // NPHASE>>j) starts at offset 2*NPHASE - 2*width. Prepending ser makes
    // every stage's input a contiguous slice of tree_in.
    assign tree_in = {tree_q[TW-2:0], ser};

    for (genvar j = 0; j < S; j++) begin : g_stage
        localparam int unsigned W     = NPHASE >> j;
        localparam int unsigned OBASE = 2 * NPHASE - 2 * W;
        localparam int unsigned IBASE = 4 * NPHASE - 4 * W;
        for (genvar i = 0; i < W; i++) begin : g_node
            assign tree_d[OBASE + i] = curphase_q[j] ? tree_in[IBASE + 2*i + 1]
                                                     : tree_in[IBASE + 2*i];
        end
    end

    // Mid-eye target sits half a unit interval after the peak edge,
    // always within the current-clock half of the phase vector.
    assign tgt       = {1'b1, PB'(best_p_q + HALF)};
    assign win_valid = (best_cnt_q >= MIN_CNT);

    always_comb begin
        serdel_d   = bus.serin;
        state_d    = state_q;
        curphase_d = curphase_q;
        locked_d   = locked_q;
        cand_d     = cand_q;
        wincnt_d   = wincnt_q;
        cnt_d      = cnt_q;
        snap_d     = snap_q;
        scan_act_d = scan_act_q;
        scan_idx_d = scan_idx_q;
        best_p_d   = best_p_q;
        best_cnt_d = best_cnt_q;
        res_d      = 1'b0;

        if (!bus.mode) begin
            state_d    = MANUAL;
            curphase_d = bus.phsel;
            locked_d   = 1'b0;
            wincnt_d   = '0;
            scan_act_d = 1'b0;
            scan_idx_d = '0;
            for (int unsigned p = 0; p < NPHASE; p++) cnt_d[p] = '0;
        end else if (state_q == MANUAL) begin
            state_d    = ACQUIRE;
            wincnt_d   = '0;
            scan_act_d = 1'b0;
            scan_idx_d = '0;
            for (int unsigned p = 0; p < NPHASE; p++) cnt_d[p] = '0;
        end else begin
            wincnt_d = wincnt_q + 1'b1;
            // The last clock's edges go into the snapshot, so consecutive
            // windows cover every clock exactly once.
            if (wincnt_q == WIN_LAST) begin
                for (int unsigned p = 0; p < NPHASE; p++) begin
                    snap_d[p] = cnt_q[p] + CW'(edge_v[p]);
                    cnt_d[p]  = '0;
                end
                scan_act_d = 1'b1;
                scan_idx_d = '0;
            end else begin
                for (int unsigned p = 0; p < NPHASE; p++)
                    cnt_d[p] = cnt_q[p] + CW'(edge_v[p]);
            end

            // Strict greater-than keeps the lowest index on ties.
            if (scan_act_q) begin
                if (scan_idx_q == '0 || snap_q[scan_idx_q] > best_cnt_q) begin
                    best_cnt_d = snap_q[scan_idx_q];
                    best_p_d   = scan_idx_q;
                end
                scan_idx_d = scan_idx_q + 1'b1;
                if (scan_idx_q == IDX_LAST) begin
                    scan_act_d = 1'b0;
                    res_d      = 1'b1;
                end
            end

            if (res_q) begin
                case (state_q)
                    ACQUIRE: begin
                        if (win_valid) begin
                            curphase_d = tgt;
                            locked_d   = 1'b1;
                            state_d    = LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (!win_valid) begin
                            locked_d = 1'b0;
                            state_d  = ACQUIRE;
                        end else if (tgt != curphase_q) begin
                            cand_d  = tgt;
                            state_d = PENDING;
                        end
                    end
                    PENDING: begin
                        if (!win_valid) begin
                            locked_d = 1'b0;
                            state_d  = ACQUIRE;
                        end else if (tgt == cand_q) begin
                            curphase_d = tgt;
                            state_d    = LOCKED;
                        end else if (tgt == curphase_q) begin
                            state_d = LOCKED;
                        end else begin
                            cand_d = tgt;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK400) begin
        if (reset) begin
            state_q    <= bus.mode ? ACQUIRE : MANUAL;
            serdel_q   <= '0;
            tree_q     <= '0;
            curphase_q <= '0;
            locked_q   <= 1'b0;
            cand_q     <= '0;
            wincnt_q   <= '0;
            cnt_q      <= '{default: '0};
            snap_q     <= '{default: '0};
            scan_act_q <= 1'b0;
            scan_idx_q <= '0;
            best_p_q   <= '0;
            best_cnt_q <= '0;
            res_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            serdel_q   <= serdel_d;
            tree_q     <= tree_d;
            curphase_q <= curphase_d;
            locked_q   <= locked_d;
            cand_q     <= cand_d;
            wincnt_q   <= wincnt_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            scan_act_q <= scan_act_d;
            scan_idx_q <= scan_idx_d;
            best_p_q   <= best_p_d;
            best_cnt_q <= best_cnt_d;
            res_q      <= res_d;
        end
    end

    assign bus.serout   = tree_q[TW-1];
    assign bus.curphase = curphase_q;
    assign bus.locked   = locked_q;

endmodule

// File: tb/tb_phase_selector_track.sv
module tb_phase_selector_track;
    localparam int NPH  = 8;
    localparam int WINL = 256;
    localparam int MINE = 16;
    localparam int S    = 4;
    localparam int HMAX = 8192;

    logic clk = 1'b0;
    logic reset;

    phase_selector_track_if #(.NPHASE(NPH)) bus ();

    phase_selector_track #(
        .NPHASE (NPH),
        .WIN    (WINL),
        .MINEDGE(MINE)
    ) dut (
        .CLK400(clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n      = 0;
    int rel    = 0;

    // Reference model: histories per clock edge plus window bookkeeping.
    logic [15:0] ser_h [HMAX];
    int          cp_h  [HMAX];
    int          last_rst = -100;
    logic [7:0]  m_serdel = '0;
    int          m_cur = 0;
    bit          m_locked = 0;
    bit          m_active = 0;
    int          m_wt = 0;
    int          m_hist [NPH];
    int          m_due = -1;
    int          m_pp = 0;
    int          m_pc = 0;
    bit          m_candv = 0;
    int          m_cand = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d at edge %0d", tag, obs, exp, n);
        end
    endtask

    task automatic clear_hist();
        for (int p = 0; p < NPH; p++) m_hist[p] = 0;
    endtask

    task automatic decide();
        int  t;
        bit  valid;
        t     = NPH + ((m_pp + NPH / 2) % NPH);
        valid = (m_pc >= MINE);
        if (!m_locked) begin
            if (valid) begin
                m_cur    = t;
                m_locked = 1;
                m_candv  = 0;
            end
        end else if (!valid) begin
            m_locked = 0;
            m_candv  = 0;
        end else if (m_candv && t == m_cand) begin
            m_cur   = t;
            m_candv = 0;
        end else if (t == m_cur) begin
            m_candv = 0;
        end else begin
            m_cand  = t;
            m_candv = 1;
        end
    endtask

    task automatic model_edge();
        logic [15:0] ser;
        n++;
        ser      = {bus.serin, m_serdel};
        ser_h[n] = ser;
        if (reset) begin
            m_serdel = '0;
            last_rst = n;
            m_cur    = 0;
            m_locked = 0;
            m_active = bus.mode;
            m_wt     = 0;
            m_due    = -1;
            m_candv  = 0;
            clear_hist();
        end else begin
            m_serdel = bus.serin;
            if (!bus.mode) begin
                m_cur    = int'(bus.phsel);
                m_locked = 0;
                m_active = 0;
                m_wt     = 0;
                m_due    = -1;
                m_candv  = 0;
                clear_hist();
            end else if (!m_active) begin
                m_active = 1;
                m_wt     = 0;
                m_due    = -1;
                clear_hist();
            end else begin
                if (m_due == n) decide();
                for (int p = 0; p < NPH; p++)
                    if (ser[NPH + p] != ser[NPH + p - 1]) m_hist[p]++;
                if (m_wt == WINL - 1) begin
                    m_pp = 0;
                    m_pc = m_hist[0];
                    for (int p = 1; p < NPH; p++)
                        if (m_hist[p] > m_pc) begin
                            m_pc = m_hist[p];
                            m_pp = p;
                        end
                    m_due = n + NPH + 1;
                    m_wt  = 0;
                    clear_hist();
                end else begin
                    m_wt++;
                end
            end
        end
        cp_h[n] = m_cur;
    endtask

    task automatic check_all();
        bit          stable;
        logic [15:0] sv;
        chk("curphase", 32'(bus.curphase), 32'(m_cur));
        chk("locked", 32'(bus.locked), 32'(m_locked));
        // serout only where every stage in flight used the same phase
        if (n - S + 1 > last_rst && n > S) begin
            stable = 1'b1;
            for (int k = n - S; k < n; k++)
                if (cp_h[k] != cp_h[n-1]) stable = 1'b0;
            if (stable) begin
                sv = ser_h[n-S+1];
                chk("serout", 32'(bus.serout), 32'(sv[cp_h[n-1]]));
            end
        end
    endtask

    task automatic tick();
        if (n >= HMAX - 2) begin
            $display("FAIL cycle_budget: observed=%0d edges expected below %0d", n, HMAX - 2);
            $fatal(1);
        end
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic run_alt(input logic [7:0] a, input logic [7:0] b, input int target);
        while (n - rel < target) begin
            bus.serin = ((n & 1) != 0) ? b : a;
            tick();
        end
    endtask

    task automatic run_rand(input int target);
        while (n - rel < target) begin
            bus.serin = 8'($urandom);
            tick();
        end
    endtask

    task automatic do_reset(input logic md);
        reset    = 1'b1;
        bus.mode = md;
        tick();
        rel = n;
        chk("rst_serout", 32'(bus.serout), 32'd0);
        chk("rst_curphase", 32'(bus.curphase), 32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        bus.mode  = 1'b0;
        bus.phsel = '0;
        bus.serin = '0;
        clear_hist();

        // Manual mode, fixed phases
        do_reset(1'b0);
        bus.serin = 8'h01;
        bus.phsel = 4'd8;
        for (int i = 0; i < 6; i++) tick();
        chk("man_p8_serout", 32'(bus.serout), 32'd1);
        bus.phsel = 4'd9;
        tick();
        chk("man_p9_curphase", 32'(bus.curphase), 32'd9);
        for (int i = 0; i < 4; i++) tick();
        chk("man_p9_serout", 32'(bus.serout), 32'd0);

        // Manual mode, random data and phase selects
        for (int i = 0; i < 48; i++) begin
            if (i % 8 == 0) bus.phsel = 4'($urandom_range(0, 15));
            bus.serin = 8'($urandom);
            tick();
        end

        // Automatic acquisition
        do_reset(1'b1);
        run_alt(8'h03, 8'hFC, 264);
        chk("acq_locked_264", 32'(bus.locked), 32'd0);
        run_alt(8'h03, 8'hFC, 265);
        chk("acq_locked_265", 32'(bus.locked), 32'd1);
        chk("acq_curphase", 32'(bus.curphase), 32'd14);

        // Hysteresis: single shifted window is ignored
        run_alt(8'h03, 8'hFC, 512);
        run_alt(8'h07, 8'hF8, 768);
        run_alt(8'h03, 8'hFC, 777);
        chk("hyst_one_cur", 32'(bus.curphase), 32'd14);
        run_alt(8'h03, 8'hFC, 1024);
        run_alt(8'h07, 8'hF8, 1289);
        chk("hyst_pend_cur", 32'(bus.curphase), 32'd14);
        run_alt(8'h07, 8'hF8, 1536);
        run_alt(8'h00, 8'h00, 1544);
        chk("hyst_two_before", 32'(bus.curphase), 32'd14);
        run_alt(8'h00, 8'h00, 1545);
        chk("hyst_two_cur", 32'(bus.curphase), 32'd15);
        chk("hyst_two_locked", 32'(bus.locked), 32'd1);

        // Low activity drops lock, pattern return relocks
        run_alt(8'h00, 8'h00, 1800);
        chk("low_locked_before", 32'(bus.locked), 32'd1);
        run_alt(8'h00, 8'h00, 1801);
        chk("low_locked", 32'(bus.locked), 32'd0);
        chk("low_curphase", 32'(bus.curphase), 32'd15);
        run_alt(8'h03, 8'hFC, 2048);
        run_alt(8'h3E, 8'h3E, 2057);
        chk("relock_locked", 32'(bus.locked), 32'd1);
        chk("relock_cur", 32'(bus.curphase), 32'd14);

        // Tie between p=1 and p=6 resolves to p=1
        run_alt(8'h3E, 8'h3E, 2313);
        chk("tie_pend_cur", 32'(bus.curphase), 32'd14);
        run_alt(8'h3E, 8'h3E, 2560);
        run_alt(8'hC0, 8'h3F, 2569);
        chk("tie_cur", 32'(bus.curphase), 32'd13);

        // Edges only at p=6 wrap the target to 10
        run_alt(8'hC0, 8'h3F, 3072);
        run_rand(3081);
        chk("wrap_cur", 32'(bus.curphase), 32'd10);

        // Random data windows
        run_rand(3584);

        // Reset mid-window restarts lock timing
        run_alt(8'h03, 8'hFC, 3684);
        do_reset(1'b1);
        run_alt(8'h03, 8'hFC, 264);
        chk("rst_mid_locked_264", 32'(bus.locked), 32'd0);
        run_alt(8'h03, 8'hFC, 265);
        chk("rst_mid_locked_265", 32'(bus.locked), 32'd1);
        chk("rst_mid_cur", 32'(bus.curphase), 32'd14);

        // Leaving automatic mode while locked
        bus.mode  = 1'b0;
        bus.phsel = 4'd5;
        tick();
        chk("mode0_locked", 32'(bus.locked), 32'd0);
        chk("mode0_cur", 32'(bus.curphase), 32'd5);
        for (int i = 0; i < 24; i++) begin
            if (i % 6 == 0) bus.phsel = 4'($urandom_range(0, 15));
            bus.serin = 8'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
